// File: rtl/cordic_pkg.sv
// Shared fp32 field constants, sequencer state encoding and fp32 field helpers.
// Used by fix2float_seq and by the cosine block's input decoder.
package cordic_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    NORM  = 2'd2,
    ROUND = 2'd3
  } state_e;

  function automatic logic [31:0] fp32_pack(input logic                   sign,
                                            input logic [FP32_EXP_W-1:0]  expo,
                                            input logic [FP32_FRAC_W-1:0] frac);
    return {sign, expo, frac};
  endfunction

  function automatic logic fp32_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [FP32_EXP_W-1:0] fp32_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [FP32_FRAC_W-1:0] fp32_frac(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/fp32_round.sv
// Combinational fraction/exponent rounding of a normalised 32-bit magnitude.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise plain truncation.
module fp32_round
  import cordic_pkg::*;
(
  input  logic [31:0]            mag,
  input  logic [FP32_EXP_W-1:0]  expo,
  output logic [FP32_FRAC_W-1:0] frac,
  output logic [FP32_EXP_W-1:0]  expo_out
);

  // mag[31] is the implicit leading one and never reaches the packed fraction
  logic unused_hidden;
  assign unused_hidden = mag[31];

`ifdef ROUND_NEAREST_EN
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [FP32_FRAC_W:0] sum;

  assign guard  = mag[7];
  assign sticky = |mag[6:0];
  assign inc    = guard & (sticky | mag[8]);
  assign sum    = {1'b0, mag[30:8]} + {{FP32_FRAC_W{1'b0}}, inc};

  // a carry out of the fraction renormalises to 1.0 x 2^(exp+1)
  assign frac     = sum[FP32_FRAC_W] ? '0 : sum[FP32_FRAC_W-1:0];
  assign expo_out = expo + {{(FP32_EXP_W-1){1'b0}}, sum[FP32_FRAC_W]};
`else
  logic unused_bits;
  assign unused_bits = ^mag[7:0];

  assign frac     = mag[30:8];
  assign expo_out = expo;
`endif

endmodule

// File: rtl/fix2float_seq.sv
// Sequential signed fixed-point to fp32 converter, one normalisation shift per cycle.
// Rounding policy lives in fp32_round (ROUND_NEAREST_EN selects nearest-even).
//
// state | meaning
// IDLE  | waiting for start; latches sign and magnitude
// ABS   | zero detect, exponent seed
// NORM  | shift left until the leading one reaches bit 31
// ROUND | round, pack result, pulse done
module fix2float_seq
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic        busy,
  output logic [31:0] result
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ABS   = ABS;
  localparam logic [1:0] ST_NORM  = NORM;
  localparam logic [1:0] ST_ROUND = ROUND;

  localparam logic [FP32_EXP_W-1:0] EXP_INIT = FP32_EXP_W'(FP32_BIAS + 31 - FRAC_BITS);

  logic [1:0]             state;
  logic                   sign;
  logic                   zero;
  logic [31:0]            mag;
  logic [FP32_EXP_W-1:0]  expo;
  logic [FP32_FRAC_W-1:0] rnd_frac;
  logic [FP32_EXP_W-1:0]  rnd_expo;

  fp32_round u_round (
    .mag      (mag),
    .expo     (expo),
    .frac     (rnd_frac),
    .expo_out (rnd_expo)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      sign   <= 1'b0;
      zero   <= 1'b0;
      mag    <= '0;
      expo   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign  <= dataa[31];
            mag   <= dataa[31] ? (~dataa + 32'd1) : dataa;
            zero  <= 1'b0;
            state <= ST_ABS;
          end
        end
        ST_ABS: begin
          if (mag == '0) begin
            zero  <= 1'b1;
            state <= ST_ROUND;
          end else begin
            expo  <= EXP_INIT;
            // already normalised: NORM would take zero cycles, so skip it
            state <= mag[31] ? ST_ROUND : ST_NORM;
          end
        end
        ST_NORM: begin
          mag  <= mag << 1;
          expo <= expo - 8'd1;
          if (mag[30]) state <= ST_ROUND;
        end
        ST_ROUND: begin
          done   <= 1'b1;
          result <= zero ? 32'h0000_0000 : fp32_pack(sign, rnd_expo, rnd_frac);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix2float_seq.sv
// Scoreboard bench for fix2float_seq: directed test-plan cases plus random operands
// checked against an arithmetic reference model.
module tb_fix2float_seq;

  localparam int FRAC_BITS = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic        done;
  logic        busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          st_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fix2float_seq #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .done    (done),
    .busy    (busy),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: locate the leading one arithmetically, scale to a 24-bit mantissa.
  function automatic logic [31:0] ref_conv(input logic [31:0] d, output int lat);
    logic   s;
    longint m, mant, rem, half;
    int     p, e;
    s = d[31];
    m = s ? ((longint'(1) << 32) - longint'(d)) : longint'(d);
    if (m == 0) begin
      lat = 3;
      return 32'h0;
    end
    p = 31;
    while (m < (longint'(1) << p)) p--;
    lat = 3 + (31 - p);
    e = 127 + p - FRAC_BITS;
    if (p >= 23) begin
      mant = m >> (p - 23);
      rem  = m - (mant << (p - 23));
    end else begin
      mant = m << (23 - p);
      rem  = 0;
    end
`ifdef ROUND_NEAREST_EN
    if (p > 23) begin
      half = longint'(1) << (p - 24);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    if (mant == (longint'(1) << 24)) begin
      mant = longint'(1) << 23;
      e++;
    end
`else
    half = rem;
`endif
    return {s, 8'(e), mant[22:0]};
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result=%h, required no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result: got %h, required %h", result, e.res);
        end
        checks++;
        if ((cyc - e.st_cyc) != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d, required %0d (result %h)", cyc - e.st_cyc, e.lat, e.res);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] d, input bit expect_it, input logic [31:0] res, input int lat);
    exp_t e;
    @(posedge clk); #1;
    dataa = d;
    start = 1'b1;
    if (expect_it) begin
      e.res = res;
      e.st_cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    dataa = $urandom;
  endtask

  task automatic wait_done(input int budget, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        sb.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bc, lat;
    logic [31:0] d, r;

    #12;
    check_val("reset_done", {31'd0, done}, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_result", result, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    issue(32'h4000_0000, 1, 32'h3F80_0000, 4);
    wait_done(60, bc);
    check_val("busy_cycles_1p0", 32'(bc), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    check_val("result_hold", result, 32'h3F80_0000);

    issue(32'hC000_0000, 1, 32'hBF80_0000, 4); wait_done(60, bc);
    issue(32'h2000_0000, 1, 32'h3F00_0000, 5); wait_done(60, bc);
    issue(32'h0000_0001, 1, 32'h3080_0000, 34); wait_done(60, bc);
    issue(32'h8000_0000, 1, 32'hC000_0000, 3); wait_done(60, bc);
    issue(32'h0000_0000, 1, 32'h0000_0000, 3); wait_done(60, bc);
`ifdef ROUND_NEAREST_EN
    issue(32'h7FFF_FFFF, 1, 32'h4000_0000, 4); wait_done(60, bc);
`else
    issue(32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, 4); wait_done(60, bc);
`endif

    // second start while busy must be ignored
    issue(32'h0000_0100, 1, 32'h3480_0000, 26);
    @(posedge clk); #1;
    dataa = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, bc);
    repeat (40) @(posedge clk);

    // clk_en low for 5 cycles mid-NORM stretches latency by 5
    issue(32'h0000_0001, 1, 32'h3080_0000, 39);
    repeat (8) @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_done(80, bc);

    // reset during NORM aborts the conversion
    issue(32'h0000_0001, 0, 32'h0, 0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_result", result, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("post_abort_result", result, 32'h0);
    check_val("post_abort_busy", {31'd0, busy}, 32'd0);
    issue(32'h4000_0000, 1, 32'h3F80_0000, 4); wait_done(60, bc);

    for (int i = 0; i < 150; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
      r = ref_conv(d, lat);
      issue(d, 1, r, lat);
      wait_done(60, bc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix2float_seq.md
Name: fix2float_seq

Overview:
Sequential converter from signed fixed-point to IEEE-754 single precision. It performs the reverse of the cosine block's float-to-fixed path: CORDIC fixed-point outputs (Q2.30 by default) become fp32 for the host.
It uses a Nios-style custom-instruction handshake (start/done with clk_en). Normalisation is iterative, one bit per cycle, to keep area small.

Parameters:
FRAC_BITS, 30, number of fractional bits in dataa; legal range 0..31.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
clk_en  input  1  when low, all state and outputs are frozen
start  input  1  one-cycle request; dataa is sampled with it
dataa  input  32  two's-complement fixed-point operand, FRAC_BITS fractional bits
done  output  1  one-cycle pulse; result is valid from this cycle
busy  output  1  high from the cycle after start is accepted until done
result  output  32  fp32 value (sign, 8-bit exponent, 23-bit fraction)

Behaviour:
- Reset (async, reset_n=0): state IDLE; done=0, busy=0, result=0x00000000. Internal registers are cleared.
- All register updates are qualified by clk_en=1. With clk_en=0 nothing advances, and a start in that cycle is not accepted.
- States:
  - IDLE: accepts start when clk_en=1. Latches sign=dataa[31] and mag=|dataa| (32-bit unsigned; 0x80000000 gives mag 0x80000000), then moves to ABS.
  - ABS: if mag==0, go to ROUND with zero flag set. Otherwise set exp = 127+31-FRAC_BITS and go to NORM.
  - NORM: while mag[31]==0, shift mag left by 1 and decrement exp. When mag[31]==1, go to ROUND. This takes k cycles, where k is the number of leading zeros of mag.
  - ROUND:
    - frac = mag[30:8], guard = mag[7], sticky = |mag[6:0]; apply rounding (see Optional Feature).
    - A carry out of frac sets frac=0 and exp+1.
    - Pack {sign, exp, frac} into result, pulse done for one cycle, return to IDLE.
    - Zero flag forces result=0x00000000, with no negative zero.
- Latency (start cycle to done cycle): 3+k cycles for nonzero input, 3 for zero input; maximum 34 (k=31).
- No overflow or underflow is possible: the exponent stays within 65..159 for all legal FRAC_BITS.
- result holds its value after done until the next done or reset.
- start while busy=1 is ignored; no queuing.
- reset_n asserted mid-operation aborts the conversion immediately: no done pulse, result=0.

Optional Feature:
- ROUND_NEAREST_EN defined: round-to-nearest-even. Increment when guard & (sticky | mag[8]).
- Undefined: truncation. guard and sticky are ignored and no increment logic is generated.
- Latency is identical in both builds.

Decomposition:
- Shared package cordic_pkg:
  - FP32_BIAS=127, FP32_EXP_W=8, FP32_FRAC_W=23.
  - State enum {IDLE, ABS, NORM, ROUND}.
  - Fp32 field extract/pack helper functions, shared with the cosine block's input decoder.
- One natural sub-module, fp32_round: combinational frac/exp rounding with carry handling. It contains the ROUND_NEAREST_EN logic so the sequencer stays policy-free.

Test Plan:
- dataa=0x40000000 (1.0) -> result=0x3F800000, done 4 cycles after start, busy high for 3 cycles.
- dataa=0xC0000000 (-1.0) -> 0xBF800000. dataa=0x20000000 (0.5) -> 0x3F000000 at latency 5.
- Extremes:
  - dataa=0x00000001 (2^-30) -> 0x30800000 at latency 34.
  - dataa=0x80000000 (-2.0) -> 0xC0000000 at latency 3.
  - dataa=0 -> 0x00000000 at latency 3.
- dataa=0x7FFFFFFF:
  - With ROUND_NEAREST_EN -> 0x40000000 (rounding carry bumps the exponent).
  - Without it -> 0x3FFFFFFF.
- Handshake and clk_en:
  - A second start while busy is ignored; the first result is still correct.
  - clk_en held low for 5 mid-NORM cycles stretches latency by exactly 5.
- Reset during NORM (after start with dataa=0x00000001): done never pulses, result=0, busy=0. The next start converts normally.
